// File: rtl/or2_sweep_checker.sv
// rtl/or2_sweep_checker.sv - exhaustive ascending sweep and response checker for a 2-input OR gate
// Optional build macro OR2_SWEEP_STOP_ON_ERR_EN: end the sweep at the first mismatch.
module or2_sweep_checker #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            y,
  output logic            a,
  output logic            b,
  output logic [N_IN-1:0] vec_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_err_vec
);

  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

  typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} state_t;

  state_t          state;
  logic [N_IN-1:0] vec;
  logic [CW-1:0]   settle_cnt;
  logic            err_seen;
  logic            mis;
  logic [N_IN:0]   err_cnt_next;
  logic            finish;

  assign vec_out = vec;
  assign a       = vec[0];
  assign b       = vec[1];

  // y is sampled directly; the gate under test is purely combinational
  assign mis          = (y != (|vec));
  assign err_cnt_next = err_cnt + {{N_IN{1'b0}}, mis};

`ifdef OR2_SWEEP_STOP_ON_ERR_EN
  assign finish = mis || (vec == LAST_VEC);
`else
  assign finish = (vec == LAST_VEC);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      vec           <= '0;
      settle_cnt    <= '0;
      err_seen      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_err_vec <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec           <= '0;
            err_cnt       <= '0;
            first_err_vec <= '0;
            err_seen      <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            busy          <= 1'b1;
            state         <= APPLY;
          end
        end
        APPLY: begin
          settle_cnt <= CW'(SETTLE);
          state      <= (SETTLE == 0) ? CHECK : WAIT;
        end
        WAIT: begin
          settle_cnt <= settle_cnt - CW'(1);
          if (settle_cnt <= CW'(1)) state <= CHECK;
        end
        CHECK: begin
          err_cnt <= err_cnt_next;
          if (mis && !err_seen) begin
            first_err_vec <= vec;
            err_seen      <= 1'b1;
          end
          // vec is left untouched on the final vector so a/b hold it in DONE
          if (finish) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt_next == '0);
            state <= DONE;
          end else begin
            vec   <= vec + N_IN'(1);
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_or2_sweep_checker.sv
// tb/tb_or2_sweep_checker.sv - directed table-driven bench for or2_sweep_checker
module tb_or2_sweep_checker;

  logic clk = 1'b0;
  logic rst, start;
  int   mode;  // 0: correct OR, 1: stuck at 0, 2: AND

  logic y1, a1, b1, busy1, done1, pass1;
  logic [1:0] vo1, fev1;
  logic [2:0] ec1;
  logic y0, a0, b0, busy0, done0, pass0;
  logic [1:0] vo0, fev0;
  logic [2:0] ec0;
  logic y3, a3, b3, busy3, done3, pass3;
  logic [1:0] vo3, fev3;
  logic [2:0] ec3;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  function automatic logic gate(input int m, input logic ga, input logic gb);
    case (m)
      1:       return 1'b0;
      2:       return ga & gb;
      default: return ga | gb;
    endcase
  endfunction

  assign y1 = gate(mode, a1, b1);
  assign y0 = gate(mode, a0, b0);
  assign y3 = gate(mode, a3, b3);

  or2_sweep_checker #(.N_IN(2), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .y(y1), .a(a1), .b(b1), .vec_out(vo1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(ec1), .first_err_vec(fev1));
  or2_sweep_checker #(.N_IN(2), .SETTLE(0)) dut_s0 (
    .clk(clk), .rst(rst), .start(start), .y(y0), .a(a0), .b(b0), .vec_out(vo0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(ec0), .first_err_vec(fev0));
  or2_sweep_checker #(.N_IN(2), .SETTLE(3)) dut_s3 (
    .clk(clk), .rst(rst), .start(start), .y(y3), .a(a3), .b(b3), .vec_out(vo3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(ec3), .first_err_vec(fev3));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " a"}, int'(a1), 0);
    chk({tag, " b"}, int'(b1), 0);
    chk({tag, " vec_out"}, int'(vo1), 0);
    chk({tag, " busy"}, int'(busy1), 0);
    chk({tag, " done"}, int'(done1), 0);
    chk({tag, " pass"}, int'(pass1), 0);
    chk({tag, " err_cnt"}, int'(ec1), 0);
    chk({tag, " first_err_vec"}, int'(fev1), 0);
  endtask

  typedef struct {
    string name;
    int    mode;
    int    pulse_at;   // cycle index for a spurious mid-sweep start, -1 for none
    int    cyc1;       // done edge relative to start edge, SETTLE=1
    int    cyc0;       // same, SETTLE=0
    int    cyc3;       // same, SETTLE=3
    int    err;
    int    first;
    int    pass;
  } row_t;

  row_t rows[4];

  initial begin
    int n, c1, c0, c3;
    logic [1:0] seq[$];

`ifdef OR2_SWEEP_STOP_ON_ERR_EN
    rows[0] = '{"or",        0, -1, 12, 8, 20, 0, 0, 1};
    rows[1] = '{"stuck0",    1, -1,  6, 4, 10, 1, 1, 0};
    rows[2] = '{"and",       2, -1,  6, 4, 10, 1, 1, 0};
    rows[3] = '{"or_pulse",  0,  5, 12, 8, 20, 0, 0, 1};
`else
    rows[0] = '{"or",        0, -1, 12, 8, 20, 0, 0, 1};
    rows[1] = '{"stuck0",    1, -1, 12, 8, 20, 3, 1, 0};
    rows[2] = '{"and",       2, -1, 12, 8, 20, 2, 1, 0};
    rows[3] = '{"or_pulse",  0,  5, 12, 8, 20, 0, 0, 1};
`endif

    rst = 1'b1; start = 1'b0; mode = 0;
    repeat (3) step();
    chk_reset_state("reset");

    // rst and start together: rst wins
    start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    step();
    chk("rst_wins busy", int'(busy1), 0);

    foreach (rows[r]) begin
      mode = rows[r].mode;
      start = 1'b1;
      step();
      start = 1'b0;
      chk({rows[r].name, " busy at start edge"}, int'(busy1), 1);
      chk({rows[r].name, " done cleared"}, int'(done1), 0);
      seq.delete();
      seq.push_back({b1, a1});
      n = 0; c1 = -1; c0 = -1; c3 = -1;
      while ((c1 < 0 || c0 < 0 || c3 < 0) && n < 100) begin
        start = (n == rows[r].pulse_at);
        step();
        n++;
        if ({b1, a1} != seq[$]) seq.push_back({b1, a1});
        if (done1 && c1 < 0) begin
          c1 = n;
          chk({rows[r].name, " busy low at done"}, int'(busy1), 0);
          chk({rows[r].name, " err_cnt"}, int'(ec1), rows[r].err);
          chk({rows[r].name, " first_err_vec"}, int'(fev1), rows[r].first);
          chk({rows[r].name, " pass"}, int'(pass1), rows[r].pass);
        end
        if (done0 && c0 < 0) c0 = n;
        if (done3 && c3 < 0) c3 = n;
      end
      start = 1'b0;
      chk({rows[r].name, " done cycle s1"}, c1, rows[r].cyc1);
      chk({rows[r].name, " done cycle s0"}, c0, rows[r].cyc0);
      chk({rows[r].name, " done cycle s3"}, c3, rows[r].cyc3);
      chk({rows[r].name, " s3 err_cnt"}, int'(ec3), rows[r].err);
      if (rows[r].mode == 0) begin
        chk({rows[r].name, " ab steps"}, seq.size(), 4);
        for (int i = 0; i < seq.size() && i < 4; i++)
          chk({rows[r].name, " ab step value"}, int'(seq[i]), i);
      end else begin
        // failing vector (stop mode) or terminal vector is held in DONE
        chk({rows[r].name, " a held"}, int'(a1), (rows[r].cyc1 == 6) ? 1 : 1);
        chk({rows[r].name, " b held"}, int'(b1), (rows[r].cyc1 == 6) ? 0 : 1);
      end
    end

    // rst during WAIT of vector 2
    mode = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("mid vec is 2", int'({b1, a1}), 2);
    chk("mid busy", int'(busy1), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_state("mid_rst");
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!done1 && n < 100) begin
      step();
      n++;
    end
    chk("post_rst done cycle", n, 12);
    chk("post_rst pass", int'(pass1), 1);

    // start held through DONE re-arms on the following edge
    mode = 1;
    start = 1'b1;
    step();
    n = 0;
    while (!done1 && n < 100) begin
      step();
      n++;
    end
`ifdef OR2_SWEEP_STOP_ON_ERR_EN
    chk("held done cycle", n, 6);
    chk("held err_cnt at done", int'(ec1), 1);
`else
    chk("held done cycle", n, 12);
    chk("held err_cnt at done", int'(ec1), 3);
`endif
    step();
    chk("rearm done cleared", int'(done1), 0);
    chk("rearm busy", int'(busy1), 1);
    chk("rearm err_cnt cleared", int'(ec1), 0);
    chk("rearm vec 0", int'({b1, a1}), 0);
    start = 1'b0;
    repeat (30) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
